// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: widths, opcodes, FSM encoding and
// the IF/ID pipeline record handed to decode.
package fetch_stage_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 16;

    // Opcode field (inst[15:12]) values shared with the decode and ALU blocks.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_RET = 4'h9;
    localparam logic [3:0] OP_BRZ = 4'hA;
    localparam logic [3:0] OP_BRN = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    // 49-bit IF/ID slot: valid, instruction, its PC and the fall-through PC.
    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus1;
    } if_id_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush beats load, load beats hold; with none of them
// the slot becomes a bubble while the PC fields keep their last value.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = 16'h0000
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.valid    <= 1'b0;
            q.inst     <= NOP_INST;
            q.pc       <= '0;
            q.pc_plus1 <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.inst  <= NOP_INST;
        end else if (load) begin
            q <= d;
        end else if (!hold) begin
            q.valid <= 1'b0;
            q.inst  <= NOP_INST;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding request
// FSM towards instruction memory and fills the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]   PC_RESET = 16'h0000,
    parameter logic [INST_W-1:0] NOP_INST = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [PC_W-1:0]   imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              id_stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              if_id_valid,
    output logic [INST_W-1:0] if_id_inst,
    output logic [PC_W-1:0]   if_id_pc,
    output logic [PC_W-1:0]   if_id_pc_plus1,
    output fetch_state_e      fsm_state
);

    // Request channel: a request transfers on a cycle where imem_req_valid and
    // imem_req_ready are both high; the response arrives on a later cycle as a
    // single imem_rsp_valid pulse, and only one request is ever outstanding.

    fetch_state_e      state, state_next;
    logic [PC_W-1:0]   pc, pc_next;
    logic [PC_W-1:0]   req_pc, req_pc_next;
    logic [INST_W-1:0] hold_inst, hold_inst_next;
    logic [PC_W-1:0]   hold_pc, hold_pc_next;
    logic              drop, drop_next;

    logic   accept;
    logic   can_load;
    logic   if_load;
    logic   if_hold;
    logic   if_flush;
    if_id_t if_d;
    if_id_t if_q;

    assign accept   = (state == S_REQ) && imem_req_ready;
    assign can_load = !if_q.valid || !id_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= PC_RESET;
            req_pc    <= '0;
            hold_inst <= '0;
            hold_pc   <= '0;
            drop      <= 1'b0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            req_pc    <= req_pc_next;
            hold_inst <= hold_inst_next;
            hold_pc   <= hold_pc_next;
            drop      <= drop_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        req_pc_next    = req_pc;
        hold_inst_next = hold_inst;
        hold_pc_next   = hold_pc;
        drop_next      = drop;
        if_load        = 1'b0;
        if_hold        = id_stall;
        if_flush       = 1'b0;
        if_d.valid     = 1'b1;
        if_d.inst      = imem_rsp_data;
        if_d.pc        = req_pc;
        if_d.pc_plus1  = pc_inc(req_pc);

        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (accept) begin
                    req_pc_next = pc;
                    pc_next     = pc_inc(pc);
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = S_REQ;
                    if (drop) begin
                        drop_next = 1'b0;
                    end else if (can_load) begin
                        if_load = 1'b1;
                    end else begin
                        hold_inst_next = imem_rsp_data;
                        hold_pc_next   = req_pc;
                        state_next     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!id_stall) begin
                    if_load       = 1'b1;
                    if_d.inst     = hold_inst;
                    if_d.pc       = hold_pc;
                    if_d.pc_plus1 = pc_inc(hold_pc);
                    state_next    = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A redirect wins over everything; a request still in flight after this
        // edge must have its eventual response thrown away.
        if (redirect_valid) begin
            pc_next        = redirect_pc;
            if_flush       = 1'b1;
            if_load        = 1'b0;
            hold_inst_next = '0;
            hold_pc_next   = '0;
            if (accept || (state == S_WAIT && !imem_rsp_valid)) begin
                state_next = S_WAIT;
                drop_next  = 1'b1;
            end else begin
                state_next = S_REQ;
                drop_next  = 1'b0;
            end
        end
    end

    fetch_stage_if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clock (clock),
        .reset (reset),
        .load  (if_load),
        .hold  (if_hold),
        .flush (if_flush),
        .d     (if_d),
        .q     (if_q)
    );

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign if_id_valid    = if_q.valid;
    assign if_id_inst     = if_q.inst;
    assign if_id_pc       = if_q.pc;
    assign if_id_pc_plus1 = if_q.pc_plus1;
    assign fsm_state      = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed per-cycle vector table, a reset-in-flight
// sequence, then random traffic checked against an in-order fetch stream model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         imem_req_valid;
    logic [15:0]  imem_req_addr;
    logic         imem_req_ready = 1'b0;
    logic         imem_rsp_valid = 1'b0;
    logic [15:0]  imem_rsp_data = 16'h0000;
    logic         id_stall = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [15:0]  redirect_pc = 16'h0000;
    logic         if_id_valid;
    logic [15:0]  if_id_inst;
    logic [15:0]  if_id_pc;
    logic [15:0]  if_id_pc_plus1;
    fetch_state_e fsm_state;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .fsm_state      (fsm_state)
    );

    typedef struct {
        logic         ready;
        logic         rsp_valid;
        logic [15:0]  rsp_data;
        logic         stall;
        logic         redir;
        logic [15:0]  redir_pc;
        fetch_state_e st;
        logic         req_valid;
        logic [15:0]  addr;
        logic         if_valid;
        logic [15:0]  inst;
        logic [15:0]  pc;
        logic [15:0]  pc1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [15:0] rd,
                                input logic stl, input logic rdr, input logic [15:0] rpc,
                                input fetch_state_e est, input logic erv, input logic [15:0] eaddr,
                                input logic eiv, input logic [15:0] einst, input logic [15:0] epc,
                                input logic [15:0] epc1);
        vec_t v;
        v.ready = rdy; v.rsp_valid = rv; v.rsp_data = rd; v.stall = stl;
        v.redir = rdr; v.redir_pc = rpc; v.st = est; v.req_valid = erv; v.addr = eaddr;
        v.if_valid = eiv; v.inst = einst; v.pc = epc; v.pc1 = epc1;
        return v;
    endfunction

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check_outputs(input string name, input fetch_state_e est, input logic erv,
                                 input logic [15:0] eaddr, input logic eiv, input logic [15:0] einst,
                                 input logic [15:0] epc, input logic [15:0] epc1);
        checks++;
        if (fsm_state !== est || imem_req_valid !== erv || imem_req_addr !== eaddr ||
            if_id_valid !== eiv || if_id_inst !== einst || if_id_pc !== epc ||
            if_id_pc_plus1 !== epc1) begin
            errors++;
            $display("FAIL %s: got st=%0d rv=%b addr=%h v=%b inst=%h pc=%h pc1=%h, required st=%0d rv=%b addr=%h v=%b inst=%h pc=%h pc1=%h",
                     name, fsm_state, imem_req_valid, imem_req_addr, if_id_valid, if_id_inst,
                     if_id_pc, if_id_pc_plus1, est, erv, eaddr, eiv, einst, epc, epc1);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [15:0] rd,
                         input logic stl, input logic rdr, input logic [15:0] rpc);
        imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
        id_stall = stl; redirect_valid = rdr; redirect_pc = rpc;
    endtask

    // Random-phase state: memory responder and expected decode stream.
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] exp_pc = 16'h0000;
    int          consumed = 0;

    initial begin
        // rdy rv data stl rdr rpc | st rv addr | v inst pc pc1
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, S_REQ, 1,16'h0000, 0,16'h0000,16'h0000,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0001, 0,16'h0000,16'h0000,16'h0000));
        vecs.push_back(mk(0,1,16'h1A42,0,0,16'h0000, S_REQ, 1,16'h0001, 1,16'h1A42,16'h0000,16'h0001));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, S_REQ, 1,16'h0001, 0,16'h0000,16'h0000,16'h0001));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, S_REQ, 1,16'h0001, 0,16'h0000,16'h0000,16'h0001));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0002, 0,16'h0000,16'h0000,16'h0001));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0002, 0,16'h0000,16'h0000,16'h0001));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0002, 0,16'h0000,16'h0000,16'h0001));
        vecs.push_back(mk(0,1,16'h2222,0,0,16'h0000, S_REQ, 1,16'h0002, 1,16'h2222,16'h0001,16'h0002));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0003, 0,16'h0000,16'h0001,16'h0002));
        vecs.push_back(mk(0,1,16'h3333,0,0,16'h0000, S_REQ, 1,16'h0003, 1,16'h3333,16'h0002,16'h0003));
        vecs.push_back(mk(1,0,16'h0000,1,0,16'h0000, S_WAIT,0,16'h0004, 1,16'h3333,16'h0002,16'h0003));
        vecs.push_back(mk(1,1,16'h4444,1,0,16'h0000, S_HOLD,0,16'h0004, 1,16'h3333,16'h0002,16'h0003));
        vecs.push_back(mk(1,0,16'h0000,1,0,16'h0000, S_HOLD,0,16'h0004, 1,16'h3333,16'h0002,16'h0003));
        vecs.push_back(mk(1,0,16'h0000,1,0,16'h0000, S_HOLD,0,16'h0004, 1,16'h3333,16'h0002,16'h0003));
        vecs.push_back(mk(0,0,16'h0000,0,0,16'h0000, S_REQ, 1,16'h0004, 1,16'h4444,16'h0003,16'h0004));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0005, 0,16'h0000,16'h0003,16'h0004));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h0040, S_WAIT,0,16'h0040, 0,16'h0000,16'h0003,16'h0004));
        vecs.push_back(mk(0,1,16'hDEAD,0,0,16'h0000, S_REQ, 1,16'h0040, 0,16'h0000,16'h0003,16'h0004));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0041, 0,16'h0000,16'h0003,16'h0004));
        vecs.push_back(mk(0,1,16'h5555,0,0,16'h0000, S_REQ, 1,16'h0041, 1,16'h5555,16'h0040,16'h0041));
        vecs.push_back(mk(1,0,16'h0000,0,1,16'h0080, S_WAIT,0,16'h0080, 0,16'h0000,16'h0040,16'h0041));
        vecs.push_back(mk(0,1,16'hBAD1,0,0,16'h0000, S_REQ, 1,16'h0080, 0,16'h0000,16'h0040,16'h0041));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0081, 0,16'h0000,16'h0040,16'h0041));
        vecs.push_back(mk(0,1,16'h6666,0,0,16'h0000, S_REQ, 1,16'h0081, 1,16'h6666,16'h0080,16'h0081));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0082, 0,16'h0000,16'h0080,16'h0081));
        vecs.push_back(mk(0,1,16'hBAD2,0,1,16'hFFFF, S_REQ, 1,16'hFFFF, 0,16'h0000,16'h0080,16'h0081));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0000, 0,16'h0000,16'h0080,16'h0081));
        vecs.push_back(mk(0,1,16'h7777,0,0,16'h0000, S_REQ, 1,16'h0000, 1,16'h7777,16'hFFFF,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0001, 0,16'h0000,16'hFFFF,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h0100, S_WAIT,0,16'h0100, 0,16'h0000,16'hFFFF,16'h0000));
        vecs.push_back(mk(0,0,16'h0000,0,1,16'h0200, S_WAIT,0,16'h0200, 0,16'h0000,16'hFFFF,16'h0000));
        vecs.push_back(mk(0,1,16'hBAD3,0,0,16'h0000, S_REQ, 1,16'h0200, 0,16'h0000,16'hFFFF,16'h0000));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0201, 0,16'h0000,16'hFFFF,16'h0000));
        vecs.push_back(mk(0,1,16'h8888,0,0,16'h0000, S_REQ, 1,16'h0201, 1,16'h8888,16'h0200,16'h0201));
        vecs.push_back(mk(1,0,16'h0000,0,0,16'h0000, S_WAIT,0,16'h0202, 0,16'h0000,16'h0200,16'h0201));

        // Clock/reset
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_outputs("reset", S_IDLE, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clock) reset = 1'b1;

        // Directed table, one row per clock cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].ready, vecs[i].rsp_valid, vecs[i].rsp_data,
                  vecs[i].stall, vecs[i].redir, vecs[i].redir_pc);
            @(posedge clock);
            #1 check_outputs($sformatf("row%0d", i), vecs[i].st, vecs[i].req_valid, vecs[i].addr,
                             vecs[i].if_valid, vecs[i].inst, vecs[i].pc, vecs[i].pc1);
        end

        // Reset pulsed while a request is in flight: outputs clear at once.
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        #2 reset = 1'b0;
        #1 check_outputs("reset_in_wait", S_IDLE, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clock);
        #1 check_outputs("reset_held", S_IDLE, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        @(negedge clock) reset = 1'b1;
        #1 check_outputs("release_idle", S_IDLE, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);
        @(posedge clock);
        #1 check_outputs("first_req", S_REQ, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000);

        // Random traffic: decode must see PCs in program order from 0, restarting
        // at each redirect target, with inst = mem(pc) and pc_plus1 = pc + 1.
        begin
            logic        prev_stuck = 1'b0;
            logic [15:0] prev_addr = 16'h0000;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                logic        acc, cons, rv, rdr;
                logic [15:0] acc_addr, c_inst, c_pc, c_pc1, rpc;
                rv  = mem_busy && (mem_cnt == 0);
                rdr = ($urandom_range(0, 29) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
                drive($urandom_range(0, 3) != 0, rv, mem_fn(mem_addr),
                      $urandom_range(0, 9) < 3, rdr, rpc);
                #1;
                if (prev_stuck) begin
                    checks++;
                    if (!imem_req_valid || imem_req_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL addr_stable cyc%0d: got valid=%b addr=%h, required valid=1 addr=%h",
                                 cyc, imem_req_valid, imem_req_addr, prev_addr);
                    end
                end
                prev_stuck = imem_req_valid && !imem_req_ready && !rdr;
                prev_addr  = imem_req_addr;
                acc      = imem_req_valid && imem_req_ready;
                acc_addr = imem_req_addr;
                cons     = if_id_valid && !id_stall && !rdr;
                c_inst   = if_id_inst;
                c_pc     = if_id_pc;
                c_pc1    = if_id_pc_plus1;
                @(posedge clock);
                #1;
                if (cons) begin
                    checks++;
                    consumed++;
                    if (c_pc !== exp_pc || c_inst !== mem_fn(exp_pc) || c_pc1 !== 16'(exp_pc + 16'd1)) begin
                        errors++;
                        $display("FAIL stream cyc%0d: got pc=%h inst=%h pc1=%h, required pc=%h inst=%h pc1=%h",
                                 cyc, c_pc, c_inst, c_pc1, exp_pc, mem_fn(exp_pc), 16'(exp_pc + 16'd1));
                    end
                end
                if (rdr) exp_pc = rpc;
                else if (cons) exp_pc = exp_pc + 16'd1;
                if (acc) begin
                    checks++;
                    if (mem_busy) begin
                        errors++;
                        $display("FAIL one_outstanding cyc%0d: got accept while busy=1, required busy=0", cyc);
                    end
                    mem_busy = 1'b1;
                    mem_cnt  = $urandom_range(0, 2);
                    mem_addr = acc_addr;
                end else if (mem_busy && rv) begin
                    mem_busy = 1'b0;
                end else if (mem_busy) begin
                    mem_cnt--;
                end
            end
        end

        checks++;
        if (consumed < 150) begin
            errors++;
            $display("FAIL progress: got %0d instructions consumed, required at least 150", consumed);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined CPU.
- Owns the PC and issues word-addressed requests to instruction memory over a valid/ready request channel with a variable-latency response.
- Captures each returned instruction into the IF/ID pipeline register that feeds the decode stage's register-read decoder.
- Handles decode stalls and taken-branch/jump redirects, including dropping stale in-flight responses.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- NOP_INST, 16'h0000, instruction driven on if_id_inst when the slot is invalid (opcode NOP).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  16  word address of the request; equals pc.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  instruction data valid; at most one per accepted request, no earlier than the cycle after acceptance.
- imem_rsp_data  in  16  returned instruction.
- id_stall  in  1  decode cannot consume; IF/ID must hold.
- redirect_valid  in  1  taken JMP/RET/BRZ/BRN from a later stage.
- redirect_pc  in  16  target PC.
- if_id_valid  out  1  IF/ID slot holds a real instruction.
- if_id_inst  out  16  instruction to decode (NOP_INST when invalid).
- if_id_pc  out  16  PC of if_id_inst.
- if_id_pc_plus1  out  16  if_id_pc + 1, modulo 2^16.

Behaviour:
- Reset (reset low, asynchronous):
  - pc = PC_RESET, state = S_IDLE, drop = 0, hold buffer cleared.
  - if_id_valid = 0, if_id_inst = NOP_INST, if_id_pc = 0, if_id_pc_plus1 = 0.
  - imem_req_valid = 0.
  - Reset asserted mid-transaction abandons the request; no response is expected afterwards.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD.
  - imem_req_valid = 1 only in S_REQ. Moore output with no combinational path from any input.
- S_IDLE: goes to S_REQ on the next edge unconditionally.
- S_REQ, on imem_req_valid & imem_req_ready:
  - req_pc <= pc; pc <= pc + 1 (wraps 16'hFFFF to 16'h0000); go to S_WAIT.
  - Otherwise stay in S_REQ with the address stable.
- S_WAIT, on imem_rsp_valid:
  - If drop = 1: discard the data, clear drop, go to S_REQ.
  - Else if IF/ID can load (!if_id_valid | !id_stall): load IF/ID with {1, rsp_data, req_pc, req_pc + 1}; go to S_REQ.
  - Else: latch the data and req_pc into the hold buffer; go to S_HOLD.
- S_HOLD: when !id_stall, load IF/ID from the hold buffer and go to S_REQ.
- IF/ID with no load this cycle:
  - If id_stall is high, all fields hold.
  - Otherwise, if_id_valid <= 0 and if_id_inst <= NOP_INST (bubble).
- Redirect (highest priority; overrides id_stall, responses and requests):
  - pc <= redirect_pc; if_id_valid <= 0; if_id_inst <= NOP_INST; hold buffer discarded.
  - Next state:
    - S_WAIT with drop = 1 if a request is outstanding whose response has not arrived by this cycle, including a request accepted in this same cycle.
    - S_REQ otherwise, including a response arriving this same cycle, which is discarded.
  - Back-to-back redirects: the last one wins; drop remains set while a request is outstanding.
- Protocol rules:
  - imem_rsp_valid outside S_WAIT is ignored.
  - Only one request is ever outstanding.
- Timing:
  - Throughput is one instruction per 2 cycles with zero-wait memory.
  - Latency from request accept at cycle N with response at N+1 is if_id_valid = 1 at N+2.
  - First request is asserted in the 2nd cycle after reset release.

Decomposition:
- Shared include cpu_defs.vh holds:
  - opcode defines (NOP, JMP, RET, BRZ, BRN, etc.), used by this and the decode/ALU blocks;
  - PC width;
  - FSM state encodings (2-bit localparams).
- One sub-module, if_id_reg: 49-bit IF/ID register with async active-low reset, load, hold and flush inputs; the parent owns the FSM and PC.

Test Plan:
- Reset, then ready = 1 and response 1 cycle later with data 16'h1A42 -> request at PC 0x0000 in the 2nd cycle after release; if_id_valid = 1, if_id_inst = 16'h1A42, if_id_pc = 0, if_id_pc_plus1 = 1.
- Memory latency 3 cycles with ready low for 2 cycles -> imem_req_addr stable while ready is low; sequential PCs 0, 1, 2; no duplicate or skipped IF/ID loads.
- id_stall held for 4 cycles while a response arrives -> FSM enters S_HOLD; IF/ID holds the old instruction; the buffered instruction is loaded on the edge after id_stall falls; no new request issues meanwhile.
- redirect_valid with redirect_pc = 16'h0040 while in S_WAIT -> IF/ID flushed to NOP; the in-flight response (16'hDEAD) is dropped; the next request address is 0x0040.
- Redirect in the same cycle as request accept, and separately the same cycle as rsp_valid -> both old responses discarded; the fetch at the target PC proceeds.
- PC = 16'hFFFF fetched -> if_id_pc_plus1 = 16'h0000, next request address 16'h0000; reset pulsed low in S_WAIT -> all outputs return to reset values immediately.
